error_check_scheduler: RTL and testbench

Round-robin scheduler that shares one registered error-checker instance (one-cycle check latency, X/Z/pattern detection) among NUM_CH requesters. It captures a requester's word, drives it into the checker, samples the checker's flag one cycle later and returns the result to the requester. It also keeps per-channel saturating error counts and a sticky alarm for consecutive failures. It sits between the channel front-ends and the shared checker in the data-integrity path.

---
 rtl/error_check_scheduler_if.sv | 32 +++
 rtl/error_check_scheduler.sv | 147 ++++++++++++++
 tb/tb_error_check_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/error_check_scheduler_if.sv
// Bundle between the channel front-ends / shared checker (master) and the scheduler (slave).
// Carries requests, checker handshake, per-channel results, counts and alarms.
interface error_check_scheduler_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]       gnt;
  logic [WIDTH-1:0]        chk_data;
  logic                    chk_valid;
  logic                    chk_err;
  logic                    rsp_valid;
  logic [CH_W-1:0]         rsp_ch;
  logic                    rsp_err;
  logic [NUM_CH*CNT_W-1:0] err_cnt;
  logic [NUM_CH-1:0]       alarm;
  logic [NUM_CH-1:0]       clr;

  modport master (
    output req, req_data, clr, chk_err,
    input  gnt, chk_data, chk_valid, rsp_valid, rsp_ch, rsp_err, err_cnt, alarm
  );

  modport slave (
    input  req, req_data, clr, chk_err,
    output gnt, chk_data, chk_valid, rsp_valid, rsp_ch, rsp_err, err_cnt, alarm
  );
endinterface

// File: rtl/error_check_scheduler.sv
// Round-robin scheduler sharing one registered error checker among NUM_CH requesters,
// with per-channel saturating error counts and a sticky consecutive-error alarm.
module error_check_scheduler #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ALARM_TH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  error_check_scheduler_if.slave  bus
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StReport} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   last_q, sel_q, pick;
  logic              pick_valid, capture;
  logic [WIDTH-1:0]  data_q;
  logic              rsp_err_q;
  int unsigned       rr_idx;

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [3:0]        cons_q [NUM_CH];
  logic [3:0]        cons_d [NUM_CH];
  logic [NUM_CH-1:0] alarm_q, alarm_d;

  // First requester after the last granted one; the last granted one has lowest priority.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    rr_idx     = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      rr_idx = (32'(last_q) + i) % NUM_CH;
      if (!pick_valid && bus.req[rr_idx]) begin
        pick       = CH_W'(rr_idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          capture = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait:  state_d = StReport;
      StReport: begin
        if (pick_valid) begin
          capture = 1'b1;
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      last_q    <= CH_W'(NUM_CH - 1);
      sel_q     <= '0;
      data_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        last_q <= pick;
        sel_q  <= pick;
        data_q <= bus.req_data[32'(pick)*WIDTH +: WIDTH];
      end
      // The checker flag is only meaningful the cycle after ISSUE.
      if (state_q == StWait) begin
        rsp_err_q <= bus.chk_err;
      end
    end
  end

  // Clear is applied before the REPORT update so a same-cycle error counts once.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c]   = cnt_q[c];
      cons_d[c]  = cons_q[c];
      alarm_d[c] = alarm_q[c];
      if (bus.clr[c]) begin
        cnt_d[c]   = '0;
        cons_d[c]  = '0;
        alarm_d[c] = 1'b0;
      end
      if (state_q == StReport && sel_q == CH_W'(c)) begin
        if (rsp_err_q) begin
          if (cnt_d[c] != {CNT_W{1'b1}}) begin
            cnt_d[c] = cnt_d[c] + 1'b1;
          end
          if (cons_d[c] < 4'(ALARM_TH)) begin
            cons_d[c] = cons_d[c] + 4'd1;
          end
          if (cons_d[c] == 4'(ALARM_TH)) begin
            alarm_d[c] = 1'b1;
          end
        end else begin
          cons_d[c] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        cons_q[c] <= '0;
      end
      alarm_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= cnt_d[c];
        cons_q[c] <= cons_d[c];
      end
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    bus.gnt       = (state_q == StIssue) ? (NUM_CH'(1) << sel_q) : '0;
    bus.chk_valid = (state_q == StIssue);
    bus.chk_data  = (state_q == StIssue) ? data_q : '0;
    bus.rsp_valid = (state_q == StReport);
    bus.rsp_ch    = sel_q;
    bus.rsp_err   = rsp_err_q;
    bus.alarm     = alarm_q;
    bus.err_cnt   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.err_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
    end
  end
endmodule

// File: tb/tb_error_check_scheduler.sv
// Directed bench for error_check_scheduler with a registered checker model that flags
// 8'hAA and any X/Z word; counters are 2 bits wide so saturation is reachable.
module tb_error_check_scheduler;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  error_check_scheduler_if #(.NUM_CH(4), .WIDTH(8), .CNT_W(2)) bus ();

  error_check_scheduler #(
    .NUM_CH  (4),
    .WIDTH   (8),
    .CNT_W   (2),
    .ALARM_TH(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Shared checker: one-cycle registered flag.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.chk_err <= 1'b0;
    else bus.chk_err <= bus.chk_valid && ((bus.chk_data == 8'hAA) || $isunknown(bus.chk_data));
  end

  function automatic logic [1:0] cnt_of(input int c);
    return bus.err_cnt[c*2 +: 2];
  endfunction

  task automatic apply_reset(input logic [3:0] r);
    reset_n = 1'b0;
    bus.req = r;
    bus.clr = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Starts in IDLE at a negedge, returns at the REPORT negedge.
  task automatic run_txn(input int ch, input logic [7:0] d);
    bus.req_data[ch*8 +: 8] = d;
    bus.req = 4'b0001 << ch;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n      = 1'b0;
    bus.req      = 4'b1111;
    bus.req_data = {4{8'h55}};
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.gnt !== 4'b0 || bus.chk_valid !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: gnt=%b chk_valid=%b rsp_valid=%b expected 0", bus.gnt,
               bus.chk_valid, bus.rsp_valid);
    end
    n_tests++;
    if (bus.chk_data !== 8'h0 || bus.rsp_ch !== 2'd0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: chk_data=%h rsp_ch=%0d rsp_err=%b expected 0", bus.chk_data,
               bus.rsp_ch, bus.rsp_err);
    end
    n_tests++;
    if (bus.err_cnt !== 8'h0 || bus.alarm !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_counts: err_cnt=%h alarm=%b expected 0", bus.err_cnt, bus.alarm);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.gnt !== 4'b0001 || bus.chk_valid !== 1'b1 || bus.chk_data !== 8'h55) begin
      n_fail++;
      $display("FAIL reset_first_grant: gnt=%b valid=%b data=%h expected 0001 1 55", bus.gnt,
               bus.chk_valid, bus.chk_data);
    end
    bus.req = '0;
  endtask

  task automatic test_fairness;
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    apply_reset(4'b1111);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      n_tests++;
      if (bus.gnt !== (4'b0001 << (j % 4)) || bus.chk_valid !== 1'b1 ||
          bus.chk_data !== 8'(8'h10 + j % 4)) begin
        n_fail++;
        $display("FAIL fair_issue[%0d]: gnt=%b valid=%b data=%h expected gnt bit %0d", j,
                 bus.gnt, bus.chk_valid, bus.chk_data, j % 4);
      end
      @(negedge clk);
      n_tests++;
      if (bus.gnt !== 4'b0 || bus.chk_valid !== 1'b0 || bus.chk_data !== 8'h0 ||
          bus.rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fair_wait[%0d]: gnt=%b valid=%b data=%h rsp_valid=%b expected all 0", j,
                 bus.gnt, bus.chk_valid, bus.chk_data, bus.rsp_valid);
      end
      @(negedge clk);
      if (j == 11) bus.req = '0;
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_ch !== 2'(j % 4) || bus.rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL fair_report[%0d]: rsp_valid=%b rsp_ch=%0d rsp_err=%b expected 1 %0d 0",
                 j, bus.rsp_valid, bus.rsp_ch, bus.rsp_err, j % 4);
      end
    end
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.gnt !== 4'b0) begin
      n_fail++;
      $display("FAIL fair_idle: rsp_valid=%b gnt=%b expected 0", bus.rsp_valid, bus.gnt);
    end
  endtask

  task automatic test_detection;
    int e2;
    e2 = 0;
    bus.req_data = {8'h55, 8'hAA, 8'h55, 8'h55};
    apply_reset(4'b1111);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j % 4 == 3) begin
        n_tests++;
        if (cnt_of(2) !== 2'(e2)) begin
          n_fail++;
          $display("FAIL det_cnt_after[%0d]: err_cnt[2]=%0d expected %0d", j, cnt_of(2), e2);
        end
      end
      @(negedge clk);
      @(negedge clk);
      if (j == 7) bus.req = '0;
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_ch !== 2'(j % 4) ||
          bus.rsp_err !== (j % 4 == 2)) begin
        n_fail++;
        $display("FAIL det_report[%0d]: valid=%b ch=%0d err=%b expected 1 %0d %b", j,
                 bus.rsp_valid, bus.rsp_ch, bus.rsp_err, j % 4, (j % 4 == 2));
      end
      if (j % 4 == 2) begin
        n_tests++;
        if (cnt_of(2) !== 2'(e2)) begin
          n_fail++;
          $display("FAIL det_cnt_during[%0d]: err_cnt[2]=%0d expected %0d", j, cnt_of(2), e2);
        end
        e2++;
      end
    end
    @(negedge clk);
    n_tests++;
    if (bus.err_cnt !== 8'b00_10_00_00 || bus.alarm !== 4'b0) begin
      n_fail++;
      $display("FAIL det_final: err_cnt=%b alarm=%b expected 00100000 0000", bus.err_cnt,
               bus.alarm);
    end
  endtask

  task automatic test_alarm;
    logic [7:0] pat [4];
    logic [1:0] exp_cnt [4];
    pat     = '{8'hAA, 8'hAA, 8'h00, 8'hAA};
    exp_cnt = '{2'd1, 2'd2, 2'd2, 2'd3};
    bus.req_data = {4{8'h55}};
    apply_reset(4'b0000);
    for (int k = 0; k < 3; k++) begin
      run_txn(1, 8'hAA);
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_ch !== 2'd1 || bus.rsp_err !== 1'b1 ||
          bus.alarm !== 4'b0) begin
        n_fail++;
        $display("FAIL alarm_report[%0d]: valid=%b ch=%0d err=%b alarm=%b expected 1 1 1 0000",
                 k, bus.rsp_valid, bus.rsp_ch, bus.rsp_err, bus.alarm);
      end
      @(negedge clk);
      n_tests++;
      if (bus.alarm !== ((k == 2) ? 4'b0010 : 4'b0000) || cnt_of(1) !== 2'(k + 1)) begin
        n_fail++;
        $display("FAIL alarm_after[%0d]: alarm=%b cnt=%0d expected %b %0d", k, bus.alarm,
                 cnt_of(1), (k == 2) ? 4'b0010 : 4'b0000, k + 1);
      end
    end
    bus.clr = 4'b0010;
    @(negedge clk);
    bus.clr = '0;
    n_tests++;
    if (bus.alarm !== 4'b0 || cnt_of(1) !== 2'd0) begin
      n_fail++;
      $display("FAIL alarm_clear: alarm=%b cnt=%0d expected 0000 0", bus.alarm, cnt_of(1));
    end
    for (int k = 0; k < 4; k++) begin
      run_txn(1, pat[k]);
      n_tests++;
      if (bus.rsp_err !== (pat[k] == 8'hAA)) begin
        n_fail++;
        $display("FAIL alarm_gap_err[%0d]: rsp_err=%b expected %b", k, bus.rsp_err,
                 (pat[k] == 8'hAA));
      end
      @(negedge clk);
      n_tests++;
      if (bus.alarm !== 4'b0 || cnt_of(1) !== exp_cnt[k]) begin
        n_fail++;
        $display("FAIL alarm_gap[%0d]: alarm=%b cnt=%0d expected 0000 %0d", k, bus.alarm,
                 cnt_of(1), exp_cnt[k]);
      end
    end
  endtask

  task automatic test_saturation;
    bus.req_data = {4{8'h55}};
    apply_reset(4'b0000);
    for (int k = 0; k < 5; k++) begin
      run_txn(0, 8'hAA);
      @(negedge clk);
    end
    n_tests++;
    if (cnt_of(0) !== 2'd3 || bus.alarm !== 4'b0001) begin
      n_fail++;
      $display("FAIL sat_count: cnt=%0d alarm=%b expected 3 0001", cnt_of(0), bus.alarm);
    end
    run_txn(0, 8'hAA);
    bus.clr = 4'b0001;
    @(negedge clk);
    bus.clr = '0;
    n_tests++;
    if (cnt_of(0) !== 2'd1 || bus.alarm !== 4'b0) begin
      n_fail++;
      $display("FAIL sat_clr_report: cnt=%0d alarm=%b expected 1 0000", cnt_of(0), bus.alarm);
    end
    run_txn(0, 8'hAA);
    @(negedge clk);
    n_tests++;
    if (cnt_of(0) !== 2'd2 || bus.alarm !== 4'b0) begin
      n_fail++;
      $display("FAIL sat_cons2: cnt=%0d alarm=%b expected 2 0000", cnt_of(0), bus.alarm);
    end
    run_txn(0, 8'hAA);
    @(negedge clk);
    n_tests++;
    if (cnt_of(0) !== 2'd3 || bus.alarm !== 4'b0001) begin
      n_fail++;
      $display("FAIL sat_cons3: cnt=%0d alarm=%b expected 3 0001", cnt_of(0), bus.alarm);
    end
  endtask

  task automatic test_reset_mid;
    bus.req_data = {4{8'h55}};
    apply_reset(4'b0000);
    run_txn(1, 8'hAA);
    @(negedge clk);
    n_tests++;
    if (cnt_of(1) !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_pre_cnt: cnt=%0d expected 1", cnt_of(1));
    end
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req = '0;
    n_tests++;
    if (bus.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_issue: gnt=%b expected 0100", bus.gnt);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.gnt !== 4'b0 || bus.err_cnt !== 8'h0) begin
      n_fail++;
      $display("FAIL mid_abort: rsp_valid=%b gnt=%b err_cnt=%h expected 0", bus.rsp_valid,
               bus.gnt, bus.err_cnt);
    end
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_rsp: rsp_valid=%b expected 0", bus.rsp_valid);
    end
    bus.req = 4'b1111;
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_restart: gnt=%b expected 0001", bus.gnt);
    end
    bus.req = '0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    clk          = 1'b0;
    reset_n      = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.clr      = '0;
    test_reset;
    test_fairness;
    test_detection;
    test_alarm;
    test_saturation;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
